// File: rtl/seq_bin2bcd.sv
// seq_bin2bcd: multi-cycle signed binary-to-BCD converter (shift-add-3).
// Converts one result bit per clock so the display path no longer carries
// a wide combinational converter. The digit, sign and overflow outputs are
// registered and change only on the edge that enters DONE, or on reset.
module seq_bin2bcd #(
   parameter int WIDTH  = 12,
   parameter int DIGITS = 4,
   parameter int LZB    = 1
) (
   input  logic                clk,
   input  logic                rst,
   input  logic                start,
   input  logic [WIDTH-1:0]    bin,
   output logic                busy,
   output logic                done,
   output logic [4*DIGITS-1:0] bcd,
   output logic [3:0]          bcd_sgn,
   output logic                ovf
);

   localparam int CW = $clog2(WIDTH + 1);
   localparam int BW = 4 * DIGITS;

   // Largest magnitude that fits in DIGITS decimal digits, at 64-bit precision
   // so the overflow test is exact whatever WIDTH is.
   function automatic logic [63:0] max_mag_f(input int n);
      logic [63:0] p;
      p = 64'd1;
      for (int i = 0; i < n; i++) p = p * 64'd10;
      return p - 64'd1;
   endfunction

   localparam logic [63:0]   MAX_MAG = max_mag_f(DIGITS);
   localparam logic [BW-1:0] BCD_RST = {BW{1'b1}} << 4;  // all blank, ones = 0
   localparam logic [3:0]    NIB_BLANK = 4'hF;
   localparam logic [3:0]    NIB_MINUS = 4'hA;

   typedef enum logic [1:0] {
      S_IDLE,
      S_SHIFT,
      S_DONE
   } state_t;

   state_t          state;
   logic [CW-1:0]   cnt;
   logic [WIDTH-1:0] mag;
   logic [BW-1:0]   scratch;
   logic            neg;
   logic            ovf_pend;

   logic [WIDTH-1:0] mag_abs;
   logic            ovf_chk;
   logic [BW-1:0]   adj;
   logic [BW-1:0]   scratch_nxt;
   logic [WIDTH-1:0] mag_nxt;
   logic [BW-1:0]   disp;
   logic            blanking;

   // Magnitude and overflow test of the input being accepted. Negating the
   // most negative value gives 2^(WIDTH-1), which is correct read as unsigned.
   always_comb begin
      mag_abs = bin[WIDTH-1] ? -bin : bin;
      ovf_chk = 64'(mag_abs) > MAX_MAG;
   end

   // One double-dabble step: add 3 to every digit >= 5, then shift in the next
   // magnitude bit. Carries out of the top digit fall off; ovf_pend covers them.
   always_comb begin
      // NOTE: every variable gets a value at the top of the block, so no
      // path through the loop can leave it unassigned and infer a latch.
      adj = scratch;
      for (int i = 0; i < DIGITS; i++) begin
         if (adj[4*i +: 4] >= 4'd5) adj[4*i +: 4] = adj[4*i +: 4] + 4'd3;
      end
      scratch_nxt = {adj[BW-2:0], mag[WIDTH-1]};
      mag_nxt     = {mag[WIDTH-2:0], 1'b0};
   end

   // Leading-zero blanking of the final digits; the ones digit always shows.
   always_comb begin
      disp     = scratch_nxt;
      blanking = (LZB != 0);
      for (int i = DIGITS - 1; i >= 1; i--) begin
         if (blanking && disp[4*i +: 4] == 4'd0) disp[4*i +: 4] = NIB_BLANK;
         else blanking = 1'b0;
      end
   end

   // Control FSM, datapath and registered outputs.
   always_ff @(posedge clk) begin
      // NOTE: non-blocking assignments throughout, so every register here
      // sees the pre-edge values of the others regardless of statement order.
      if (rst) begin
         state    <= S_IDLE;
         busy     <= 1'b0;
         done     <= 1'b0;
         ovf      <= 1'b0;
         bcd      <= BCD_RST;
         bcd_sgn  <= NIB_BLANK;
         cnt      <= '0;
         mag      <= '0;
         scratch  <= '0;
         neg      <= 1'b0;
         ovf_pend <= 1'b0;
      end else begin
         case (state)
            S_IDLE: begin
               if (start) begin
                  neg      <= bin[WIDTH-1];
                  mag      <= mag_abs;
                  ovf_pend <= ovf_chk;
                  cnt      <= CW'(WIDTH);
                  scratch  <= '0;
                  busy     <= 1'b1;
                  state    <= S_SHIFT;
               end
            end
            S_SHIFT: begin
               scratch <= scratch_nxt;
               mag     <= mag_nxt;
               cnt     <= cnt - CW'(1);
               if (cnt == CW'(1)) begin
                  state <= S_DONE;
                  done  <= 1'b1;
                  if (ovf_pend) begin
                     bcd     <= {BW{1'b1}};
                     bcd_sgn <= NIB_BLANK;
                     ovf     <= 1'b1;
                  end else begin
                     bcd     <= disp;
                     // A negative input always has a nonzero magnitude.
                     bcd_sgn <= neg ? NIB_MINUS : NIB_BLANK;
                     ovf     <= 1'b0;
                  end
               end
            end
            S_DONE: begin
               done  <= 1'b0;
               busy  <= 1'b0;
               state <= S_IDLE;
            end
            default: begin
               busy  <= 1'b0;
               done  <= 1'b0;
               state <= S_IDLE;
            end
         endcase
      end
   end

endmodule

// File: tb/tb_seq_bin2bcd.sv
// Self-checking bench for seq_bin2bcd. Three instances share the stimulus:
// the default configuration, a 3-digit one (overflow) and one without
// leading-zero blanking. Expected values come from decimal arithmetic.
module tb_seq_bin2bcd;

   logic        clk = 1'b0;
   logic        rst = 1'b1;
   logic        start = 1'b0;
   logic [11:0] bin = '0;

   logic        busy0, done0, ovf0;
   logic [15:0] bcd0;
   logic [3:0]  sgn0;
   logic        busy1, done1, ovf1;
   logic [11:0] bcd1;
   logic [3:0]  sgn1;
   logic        busy2, done2, ovf2;
   logic [15:0] bcd2;
   logic [3:0]  sgn2;

   int total = 0;
   int bad   = 0;

   seq_bin2bcd #(.WIDTH(12), .DIGITS(4), .LZB(1)) u_dut (
      .clk(clk), .rst(rst), .start(start), .bin(bin),
      .busy(busy0), .done(done0), .bcd(bcd0), .bcd_sgn(sgn0), .ovf(ovf0));

   seq_bin2bcd #(.WIDTH(12), .DIGITS(3), .LZB(1)) u_d3 (
      .clk(clk), .rst(rst), .start(start), .bin(bin),
      .busy(busy1), .done(done1), .bcd(bcd1), .bcd_sgn(sgn1), .ovf(ovf1));

   seq_bin2bcd #(.WIDTH(12), .DIGITS(4), .LZB(0)) u_nolzb (
      .clk(clk), .rst(rst), .start(start), .bin(bin),
      .busy(busy2), .done(done2), .bcd(bcd2), .bcd_sgn(sgn2), .ovf(ovf2));

   always #5 clk = ~clk;

   task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
      total++;
      if (got !== exp) begin
         bad++;
         $display("FAIL %s: got=%h exp=%h at %0t", tag, got, exp, $time);
      end
   endtask

   // Decimal reference: digits by division, blanking by scanning from the top.
   task automatic model(input logic [11:0] b, input int digits, input bit lzb,
                        output logic [15:0] e_bcd, output logic [3:0] e_sgn,
                        output logic e_ovf);
      int v, m, lim;
      bit blank;
      logic [3:0] d [4];
      v   = int'($signed(b));
      m   = (v < 0) ? -v : v;
      lim = (10 ** digits) - 1;
      e_bcd = '0;
      if (m > lim) begin
         for (int i = 0; i < digits; i++) e_bcd[4*i +: 4] = 4'hF;
         e_sgn = 4'hF;
         e_ovf = 1'b1;
      end else begin
         for (int i = 0; i < digits; i++) d[i] = 4'((m / (10 ** i)) % 10);
         blank = lzb;
         for (int i = digits - 1; i >= 1; i--) begin
            if (blank && d[i] == 4'd0) d[i] = 4'hF;
            else blank = 1'b0;
         end
         for (int i = 0; i < digits; i++) e_bcd[4*i +: 4] = d[i];
         e_sgn = (v < 0) ? 4'hA : 4'hF;
         e_ovf = 1'b0;
      end
   endtask

   task automatic check_results(input logic [11:0] b);
      logic [15:0] eb;
      logic [3:0]  es;
      logic        eo;
      model(b, 4, 1'b1, eb, es, eo);
      check("bcd4", bcd0, eb);
      check("sgn4", sgn0, es);
      check("ovf4", ovf0, eo);
      model(b, 3, 1'b1, eb, es, eo);
      check("bcd3", {4'h0, bcd1}, eb);
      check("sgn3", sgn1, es);
      check("ovf3", ovf1, eo);
      model(b, 4, 1'b0, eb, es, eo);
      check("bcd_nolzb", bcd2, eb);
      check("sgn_nolzb", sgn2, es);
      check("ovf_nolzb", ovf2, eo);
   endtask

   // Single conversion: busy must last WIDTH+1 samples with one done pulse on
   // the last of them, WIDTH edges after the accepting edge.
   task automatic run_conv(input logic [11:0] b);
      int n, busy_cnt, lat, dn0, dn1, dn2;
      @(negedge clk);
      start = 1'b1;
      bin   = b;
      @(posedge clk);
      #1;
      start = 1'b0;
      bin   = 12'($urandom);
      n = 0; busy_cnt = 0; lat = -1; dn0 = 0; dn1 = 0; dn2 = 0;
      while (busy0 === 1'b1 && n < 100) begin
         busy_cnt++;
         if (done0 === 1'b1) begin dn0++; lat = n; end
         if (done1 === 1'b1) dn1++;
         if (done2 === 1'b1) dn2++;
         @(posedge clk);
         #1;
         n++;
      end
      check("busy_len", busy_cnt, 13);
      check("done_lat", lat, 12);
      check("done_cnt", dn0, 1);
      check("done_cnt3", dn1, 1);
      check("done_cnt_nolzb", dn2, 1);
      check_results(b);
   endtask

   initial begin
      logic [11:0] dir [10];
      int seen, k;
      dir = '{12'd5, 12'h800, 12'hFFF, 12'd0, 12'd1000, 12'd999,
              12'd1007, 12'd70, 12'h7FF, 12'h801};

      // Reset state
      repeat (2) @(posedge clk);
      #1;
      check("rst_busy", busy0, 1'b0);
      check("rst_done", done0, 1'b0);
      check("rst_bcd", bcd0, 16'hFFF0);
      check("rst_bcd3", bcd1, 12'hFF0);
      check("rst_sgn", sgn0, 4'hF);
      check("rst_ovf", ovf0, 1'b0);
      @(negedge clk);
      rst = 1'b0;

      // Directed values, then random ones
      foreach (dir[i]) run_conv(dir[i]);
      for (int i = 0; i < 30; i++) run_conv(12'($urandom_range(0, 4095)));

      // Start ignored while busy; start held high through DONE
      @(negedge clk);
      start = 1'b1;
      bin   = 12'd123;
      @(posedge clk);
      #1;
      start = 1'b0;
      bin   = 12'd555;
      for (int n = 1; n <= 14; n++) begin
         @(negedge clk);
         if (n == 5) begin start = 1'b1; bin = 12'd456; end
         else if (n >= 11) begin start = 1'b1; bin = 12'd789; end
         else start = 1'b0;
         @(posedge clk);
         #1;
         check($sformatf("hold_done_%0d", n), done0, n == 12);
         check($sformatf("hold_busy_%0d", n), busy0, n != 13);
         if (n == 12) check("hold_bcd_123", bcd0, 16'hF123);
      end
      @(negedge clk);
      start = 1'b0;
      k = 0;
      while (busy0 === 1'b1 && k < 100) begin
         @(posedge clk);
         #1;
         k++;
      end
      check("held_conv_end", busy0, 1'b0);
      check("held_bcd_789", bcd0, 16'hF789);
      check("held_sgn_789", sgn0, 4'hF);

      // Reset in the middle of a conversion
      @(negedge clk);
      start = 1'b1;
      bin   = 12'd321;
      @(posedge clk);
      #1;
      start = 1'b0;
      repeat (5) @(posedge clk);
      @(negedge clk);
      rst = 1'b1;
      @(posedge clk);
      #1;
      check("midrst_busy", busy0, 1'b0);
      check("midrst_done", done0, 1'b0);
      check("midrst_bcd", bcd0, 16'hFFF0);
      check("midrst_sgn", sgn0, 4'hF);
      check("midrst_ovf", ovf0, 1'b0);
      @(negedge clk);
      rst = 1'b0;
      seen = 0;
      repeat (20) begin
         @(posedge clk);
         #1;
         if (done0 === 1'b1 || busy0 === 1'b1) seen++;
      end
      check("midrst_quiet", seen, 0);
      run_conv(12'd321);

      $display("test done: total=%0d bad=%0d", total, bad);
      $finish;
   end

endmodule

// File: doc/seq_bin2bcd.md
Name: seq_bin2bcd

Overview:
- Multi-cycle signed binary-to-BCD converter using shift-add-3 (double dabble), one result bit per clock.
- Sits between the ALU result bus and the per-digit BCD-to-seven-segment decoders.
- Replaces the wide combinational converter on the 2*width result path, which is the longest combinational path in the display chain.
- Delivers registered digit and sign nibbles with a start/busy/done handshake.

Parameters:
- WIDTH, 12, width of the two's-complement input `bin`.
- DIGITS, 4, number of BCD digits produced.
- LZB, 1, leading-zero blanking enable (1 = blank leading zeros, 0 = show all digits).

Ports:
- clk  input  1  system clock, all logic on rising edge.
- rst  input  1  synchronous reset, active-high.
- start  input  1  request a conversion of `bin`; honoured only when busy=0.
- bin  input  WIDTH  signed two's-complement value, sampled on the accepting edge.
- busy  output  1  high while a conversion is in flight (state != IDLE).
- done  output  1  one-cycle pulse, high when new results first appear.
- bcd  output  4*DIGITS  digit nibbles; [3:0] is ones, [4*DIGITS-1 -: 4] is the most significant digit.
- bcd_sgn  output  4  sign nibble: 4'hA = minus, 4'hF = blank.
- ovf  output  1  magnitude exceeded 10^DIGITS-1 on the last conversion.

Behaviour:
- Reset (rst=1 at an edge, any state, including mid-conversion):
  - state goes to IDLE.
  - busy=0, done=0, ovf=0.
  - bcd = all 4'hF except ones digit = 4'h0.
  - bcd_sgn = 4'hF.
  - The in-flight conversion is discarded; no done is produced for it.
- FSM has three states: IDLE, SHIFT, DONE.
- IDLE:
  - On an edge with start=1, capture the following, then go to SHIFT:
    - neg = bin[WIDTH-1].
    - mag = |bin| as a WIDTH-bit unsigned value. The most negative input, -2^(WIDTH-1), yields 2^(WIDTH-1); no wrap.
    - ovf_pend = (mag > 10^DIGITS-1), compared at full precision.
    - Load the shift counter with WIDTH and clear the BCD scratch register.
  - start=0: remain in IDLE.
- SHIFT, each cycle:
  - Every scratch digit >= 5 gets +3.
  - Then {scratch, mag} shifts left by 1.
  - The counter decrements; on the cycle it reaches 0, go to DONE.
  - Exactly WIDTH cycles are spent in SHIFT.
  - Carries out of the top scratch digit are dropped; ovf_pend alone defines overflow.
- DONE (exactly one cycle, then IDLE):
  - done=1 and busy=1.
  - Output registers are written on the edge entering DONE, so they are valid during the done cycle.
  - ovf_pend=1: bcd = all 4'hF, bcd_sgn = 4'hF, ovf=1.
  - ovf_pend=0:
    - bcd = the scratch digits. With LZB=1, every zero digit above the highest nonzero digit becomes 4'hF; the ones digit is never blanked.
    - bcd_sgn = 4'hA if neg and mag != 0, else 4'hF.
    - ovf=0.
- Latency:
  - start is sampled at edge k.
  - busy=1 during cycles k+1 .. k+WIDTH+1.
  - done=1 during cycle k+WIDTH+1, i.e. 13 cycles for the default WIDTH=12.
- Handshake rules:
  - start while busy=1 (including the DONE cycle) is ignored and not queued.
  - start held continuously gives back-to-back conversions: accepted again at the first IDLE edge, one idle cycle between done and the next busy.
- Outputs bcd, bcd_sgn and ovf hold their last values between conversions. They change only on the edge entering DONE, or on reset.
- bin may change freely after the accepting edge.

Test Plan:
- Reset, then start with bin=12'd5 (WIDTH=12, DIGITS=4, LZB=1) -> done in cycle k+13; bcd=16'hFFF5, bcd_sgn=4'hF, ovf=0; busy high exactly 13 cycles.
- bin=-2048 (12'h800) -> bcd=16'h2048, bcd_sgn=4'hA, ovf=0. Then bin=-1 -> bcd=16'hFFF1, bcd_sgn=4'hA. Then bin=0 -> bcd=16'hFFF0, bcd_sgn=4'hF.
- Overflow (DIGITS=3, WIDTH=12): bin=12'd1000 -> ovf=1, bcd=12'hFFF, bcd_sgn=4'hF. Then bin=12'd999 -> ovf=0, bcd=12'h999.
- bin=12'd1007 with LZB=0 -> bcd=16'h1007; with LZB=1 -> 16'h1007 (internal zeros never blanked). bin=12'd70 with LZB=1 -> 16'hFF70.
- Start at k with bin=12'd123, pulse start again at k+5 with bin=12'd456:
  - Only 123 is converted; one done pulse.
  - Start held high through the done cycle: the next conversion is accepted at edge k+14 with busy back high at k+15.
- Start with bin=12'd321, rst=1 at edge k+6:
  - busy=0 and outputs at reset values from k+7.
  - No done pulse.
  - A fresh start afterwards converts correctly.
